// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the sequential Booth multiplier
// Contents:
//   state_t : controller states IDLE / RUN / DONE
//   clog2   : bits needed to hold values 0..value-1 (sizes the step counter)
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth add/subtract followed by an arithmetic right shift
// Ports:
//   acc, q, q_m1              : current {A, Q, q-1} register (A and Q are WIDTH+1 bits)
//   m                         : extended multiplicand (WIDTH+1 bits)
//   acc_next, q_next, q_m1_next : register contents after this step
module booth_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] acc,
    input  logic [WIDTH:0] q,
    input  logic           q_m1,
    input  logic [WIDTH:0] m,
    output logic [WIDTH:0] acc_next,
    output logic [WIDTH:0] q_next,
    output logic           q_m1_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        // Arithmetic shift of the concatenated {A, Q, q-1}: A's sign bit is replicated.
        acc_next  = {sum[WIDTH], sum[WIDTH:1]};
        q_next    = {sum[0], q[WIDTH:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle signed/unsigned Booth multiplier with start/busy/done handshake
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start             : request; a, b, signed_mode are captured when accepted (IDLE or DONE)
//   signed_mode       : 1 = two's-complement operands, 0 = unsigned
//   a, b              : multiplicand, multiplier
//   busy              : high while Booth steps are running
//   done              : one-cycle pulse when y_hi/y_lo carry a fresh product
//   y_hi, y_lo        : upper/lower halves of the 2*WIDTH-bit product, held until next completion
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y_hi,
    output logic [WIDTH-1:0] y_lo
);

    localparam int CW = clog2(WIDTH + 2);
    // WIDTH+1 steps: the extra sign bit lets one datapath serve both signed and unsigned operands.
    localparam logic [CW-1:0] STEPS = CW'(WIDTH + 1);
    localparam logic [CW-1:0] LAST  = CW'(1);

    state_t         state;
    state_t         state_next;
    logic           load;
    logic [CW-1:0]  cnt;
    logic [WIDTH:0] acc;
    logic [WIDTH:0] q;
    logic [WIDTH:0] m;
    logic           q_m1;
    logic [WIDTH:0] acc_next;
    logic [WIDTH:0] q_next;
    logic           q_m1_next;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc),
        .q         (q),
        .q_m1      (q_m1),
        .m         (m),
        .acc_next  (acc_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            q    <= '0;
            q_m1 <= 1'b0;
            m    <= '0;
            cnt  <= '0;
            y_hi <= '0;
            y_lo <= '0;
        end else if (load) begin
            acc  <= '0;
            q    <= {signed_mode & b[WIDTH-1], b};
            q_m1 <= 1'b0;
            m    <= {signed_mode & a[WIDTH-1], a};
            cnt  <= STEPS;
        end else if (state == RUN) begin
            acc  <= acc_next;
            q    <= q_next;
            q_m1 <= q_m1_next;
            cnt  <= cnt - LAST;
            if (cnt == LAST) begin
                // Low 2*WIDTH bits of the {A,Q} product after the final step.
                y_hi <= {acc_next[WIDTH-2:0], q_next[WIDTH]};
                y_lo <= q_next[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=8
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4 = 1'b1, start4 = 1'b0, sm4 = 1'b0, busy4, done4;
    logic [3:0] a4 = '0, b4 = '0, yh4, yl4;
    logic       rst8 = 1'b1, start8 = 1'b0, sm8 = 1'b0, busy8, done8;
    logic [7:0] a8 = '0, b8 = '0, yh8, yl8;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .y_hi(yh4), .y_lo(yl4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .y_hi(yh8), .y_lo(yl8)
    );

    int vectors = 0;
    int misc    = 0;
    bit chk     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product of two w-bit operands, truncated to 2*w bits.
    function automatic logic [63:0] ref_prod(input int w, input bit sm,
                                             input logic [31:0] a, input logic [31:0] b);
        longint av, bv, p;
        logic [63:0] mask;
        av = longint'(a);
        bv = longint'(b);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        p = av * bv;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    // Behavioural model: rem = Booth edges still to go (0 = able to accept a request).
    int          rem4 = 0, rem8 = 0, acc4 = 0, acc8 = 0;
    bit          m_done4 = 1'b0, m_done8 = 1'b0;
    logic [7:0]  m_y4 = '0, pend4 = '0;
    logic [15:0] m_y8 = '0, pend8 = '0;

    always @(posedge clk) begin
        if (rst4) begin
            rem4 = 0; m_done4 = 1'b0; m_y4 = '0;
        end else if (rem4 > 0) begin
            rem4 = rem4 - 1;
            m_done4 = (rem4 == 0);
            if (rem4 == 0) m_y4 = pend4;
        end else begin
            m_done4 = 1'b0;
            if (start4) begin
                rem4 = 5;
                pend4 = 8'(ref_prod(4, sm4, 32'(a4), 32'(b4)));
                acc4++;
            end
        end
    end

    always @(posedge clk) begin
        if (rst8) begin
            rem8 = 0; m_done8 = 1'b0; m_y8 = '0;
        end else if (rem8 > 0) begin
            rem8 = rem8 - 1;
            m_done8 = (rem8 == 0);
            if (rem8 == 0) m_y8 = pend8;
        end else begin
            m_done8 = 1'b0;
            if (start8) begin
                rem8 = 9;
                pend8 = 16'(ref_prod(8, sm8, 32'(a8), 32'(b8)));
                acc8++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("busy4", busy4, rem4 > 0);
            check("done4", done4, m_done4);
            check("y4",    {yh4, yl4}, m_y4);
            check("busy8", busy8, rem8 > 0);
            check("done8", done8, m_done8);
            check("y8",    {yh8, yl8}, m_y8);
        end
    end

    // Called #1 after the accepting edge; returns edges to done and busy samples seen.
    task automatic wait_done4(output int n, output int bc);
        n = 0;
        bc = int'(busy4);
        while (!done4 && n < 30) begin
            @(posedge clk); #1;
            n++;
            bc += int'(busy4);
        end
    endtask

    task automatic wait_done8(output int n, output int bc);
        n = 0;
        bc = int'(busy8);
        while (!done8 && n < 30) begin
            @(posedge clk); #1;
            n++;
            bc += int'(busy8);
        end
    endtask

    // Starts immediately (caller is #1 after an edge); returns in the DONE cycle.
    task automatic op4(input bit sm, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        int n, bc;
        start4 = 1'b1; sm4 = sm; a4 = a; b4 = b;
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_done4(n, bc);
        check("lat4", n, 5);
        check("busy_len4", bc, 5);
        check("prod4", {yh4, yl4}, exp);
    endtask

    task automatic op8(input bit sm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int n, bc;
        start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(n, bc);
        check("lat8", n, 9);
        check("busy_len8", bc, 9);
        check("prod8", {yh8, yl8}, exp);
    endtask

    task automatic rand4(input bit mode);
        int target, cap;
        target = acc4 + 1000;
        cap = 0;
        while (acc4 < target && cap < 20000) begin
            start4 = ($urandom % 4) != 0;
            sm4 = mode;
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            @(posedge clk); #1;
            cap++;
        end
        start4 = 1'b0;
        check("rand4_ops", acc4 >= target, 1);
    endtask

    task automatic rand8(input bit mode);
        int target, cap;
        target = acc8 + 1000;
        cap = 0;
        while (acc8 < target && cap < 30000) begin
            start8 = ($urandom % 4) != 0;
            sm8 = mode;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(posedge clk); #1;
            cap++;
        end
        start8 = 1'b0;
        check("rand8_ops", acc8 >= target, 1);
    endtask

    initial begin
        int n, bc;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        check("rst_y4", {yh4, yl4}, 0);
        check("rst_busy8", busy8, 0);
        check("rst_y8", {yh8, yl8}, 0);
        chk = 1'b1;
        rst4 = 1'b0;
        rst8 = 1'b0;

        check("model_m6x3", ref_prod(4, 1'b1, 32'hA, 32'h3), 64'hEE);
        check("model_u15x15", ref_prod(4, 1'b0, 32'hF, 32'hF), 64'hE1);
        check("model_m128sq", ref_prod(8, 1'b1, 32'h80, 32'h80), 64'h4000);

        // Back-to-back signed: each next start is raised in the DONE cycle.
        op4(1'b1, 4'd3, 4'd3, 8'h09);
        op4(1'b1, 4'hA, 4'd3, 8'hEE);
        op4(1'b1, 4'hF, 4'd7, 8'hF9);
        op4(1'b1, 4'h8, 4'd7, 8'hC8);
        @(posedge clk); #1;

        op4(1'b1, 4'h8, 4'h8, 8'h40);
        @(posedge clk); #1;
        op4(1'b0, 4'hF, 4'hF, 8'hE1);
        @(posedge clk); #1;
        op4(1'b0, 4'h8, 4'h0, 8'h00);
        @(posedge clk); #1;

        // Abort on the third RUN cycle.
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'd7; b4 = 4'd7;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        check("abort_busy", busy4, 0);
        check("abort_done", done4, 0);
        check("abort_y", {yh4, yl4}, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", done4, 0);
        end
        op4(1'b0, 4'd2, 4'd5, 8'h0A);
        @(posedge clk); #1;

        // start held through RUN with changed operands.
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'd2; b4 = 4'd3;
        @(posedge clk); #1;
        a4 = 4'd7; b4 = 4'd7;
        wait_done4(n, bc);
        check("hold_lat", n, 5);
        check("hold_first", {yh4, yl4}, 8'h06);
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_done4(n, bc);
        check("hold_lat2", n, 5);
        check("hold_second", {yh4, yl4}, 8'h31);
        @(posedge clk); #1;

        op8(1'b1, 8'h80, 8'h80, 16'h4000);
        @(posedge clk); #1;
        op8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
        @(posedge clk); #1;

        fork
            begin rand4(1'b1); rand4(1'b0); end
            begin rand8(1'b1); rand8(1'b0); end
        join
        repeat (12) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
